// File: rtl/e1_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : e1_tx_framer
// Description : Transmit-side E1 framer. Pulls one byte per timeslot from a
//               timeslot-indexed source and inserts the FAS/NFAS word in TS0
//               when framing is enabled. It serialises 256-bit frames
//               MSB-first, emitting one bit per out_ready strobe. CRC-4 is not
//               generated, so the Si bit is always sent as 1.
// Ports       : clk, rst            - clock, async active-high reset
//               in_data/in_valid    - source byte for timeslot in_ts
//               in_ts/in_ack        - next timeslot to load / consumed pulse
//               out_bit/out_valid   - serial bit and its one-cycle strobe
//               out_ready           - line-side bit request
//               ctrl_do_framing     - 1: TS0 generated, 0: TS0 transparent
//               alarm               - remote alarm (A bit of NFAS)
//               status_underrun     - load happened without valid data
//               status_sof          - TS0 bit 0 emitted
// Revision    : 1.0 - initial release
// ============================================================================
module e1_tx_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [4:0] in_ts,
    output logic       in_ack,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       ctrl_do_framing,
    input  logic       alarm,
    output logic       status_underrun,
    output logic       status_sof
);

    localparam logic [7:0] C_FAS  = 8'h9B;
    localparam logic [7:0] C_IDLE = 8'hFF;

    logic [2:0] r_bit_cnt;
    logic [4:0] r_ts_cnt;
    logic       r_frame_odd;
    logic [7:0] r_sr;

    logic       w_load;
    logic       w_ts0_framed;
    logic [7:0] w_word;
    logic       w_underrun;

    assign w_load       = out_ready && (r_bit_cnt == 3'd0);
    assign w_ts0_framed = ctrl_do_framing && (r_ts_cnt == 5'd0);

    // Word loaded at the start of each timeslot. In framed TS0 the source
    // byte is ignored, so a missing byte there is not an underrun.
    always_comb begin
        w_word     = C_IDLE;
        w_underrun = 1'b0;
        if (w_ts0_framed) begin
            w_word = r_frame_odd ? {2'b11, alarm, 5'b11111} : C_FAS;
        end else if (in_valid) begin
            w_word = in_data;
        end else begin
            w_underrun = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt       <= 3'd0;
            r_ts_cnt        <= 5'd0;
            r_frame_odd     <= 1'b0;
            r_sr            <= 8'd0;
            in_ts           <= 5'd0;
            in_ack          <= 1'b0;
            out_bit         <= 1'b0;
            out_valid       <= 1'b0;
            status_underrun <= 1'b0;
            status_sof      <= 1'b0;
        end else begin
            out_valid       <= out_ready;
            in_ack          <= w_load;
            status_underrun <= w_load && w_underrun;
            status_sof      <= w_load && (r_ts_cnt == 5'd0);

            if (out_ready) begin
                if (r_bit_cnt == 3'd0) begin
                    out_bit <= w_word[7];
                    r_sr    <= {w_word[6:0], 1'b0};
                    // ts_cnt only advances at the end of this byte, so the
                    // next load's timeslot is ts_cnt + 1 already.
                    in_ts   <= r_ts_cnt + 5'd1;
                end else begin
                    out_bit <= r_sr[7];
                    r_sr    <= {r_sr[6:0], 1'b0};
                end

                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_ts_cnt <= r_ts_cnt + 5'd1;
                    if (r_ts_cnt == 5'd31) begin
                        r_frame_odd <= ~r_frame_odd;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e1_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_e1_tx_framer
// Description : Scoreboard bench for e1_tx_framer. The driver pushes the
//               expected byte for every timeslot load; a monitor reassembles
//               serial bits and compares whole bytes, plus SOF position,
//               in_ack and underrun counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e1_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [4:0] in_ts;
    logic       in_ack;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       ctrl_do_framing;
    logic       alarm;
    logic       status_underrun;
    logic       status_sof;

    always #5 clk = ~clk;

    e1_tx_framer u_dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ts           (in_ts),
        .in_ack          (in_ack),
        .out_bit         (out_bit),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .ctrl_do_framing (ctrl_do_framing),
        .alarm           (alarm),
        .status_underrun (status_underrun),
        .status_sof      (status_sof)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    // driver-side frame model
    int tb_bit, tb_ts, tb_frame;
    int exp_loads, exp_under, exp_bits;

    // monitor state
    int         mon_bits, mon_acks, mon_under;
    logic [7:0] mon_sh;

    // source behaviour
    logic       drop_en;
    logic [7:0] ts0_val;
    int         src_delay = 3;

    function automatic logic [7:0] src_val(input logic [4:0] ts);
        return (ts == 5'd0) ? ts0_val : {3'b000, ts};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source: after each in_ack, withdraw data and present the next
    // timeslot's byte src_delay cycles later (or withhold it if dropped).
    initial begin
        in_data  = src_val(5'd0);
        in_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_data  = src_val(5'd0);
                in_valid = 1'b1;
            end else if (in_ack) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
                repeat (src_delay) @(posedge clk);
                #1;
                if (!(drop_en && in_ts == 5'd5)) begin
                    in_data  = src_val(in_ts);
                    in_valid = 1'b1;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            mon_bits  = 0;
            mon_acks  = 0;
            mon_under = 0;
            mon_sh    = 8'h00;
        end else begin
            if (in_ack) mon_acks++;
            if (status_underrun) mon_under++;
            if (status_sof && !out_valid) begin
                n_fail++;
                $display("FAIL sof_without_valid: got 1, expected 0 (t=%0t)", $time);
            end
            if (out_valid) begin
                check("sof_position", {31'd0, status_sof}, {31'd0, (mon_bits % 256) == 0});
                mon_sh = {mon_sh[6:0], out_bit};
                mon_bits++;
                if (mon_bits % 8 == 0) begin
                    if (exp_q.size() == 0)
                        check("byte_unexpected", 32'd1, 32'd0);
                    else
                        check($sformatf("byte%0d", mon_bits / 8 - 1), {24'd0, mon_sh},
                              {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // One out_ready strobe followed by gap-1 idle cycles; called at a negedge.
    task automatic strobe(input int gap);
        logic [7:0] e;
        if (tb_bit == 0) begin
            if (ctrl_do_framing && tb_ts == 0)
                e = (tb_frame != 0) ? (alarm ? 8'hFF : 8'hDF) : 8'h9B;
            else if (drop_en && tb_ts == 5) begin
                e = 8'hFF;
                exp_under++;
            end else
                e = src_val(tb_ts[4:0]);
            exp_q.push_back(e);
            exp_loads++;
            check("in_ts_at_load", {27'd0, in_ts}, tb_ts);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (gap - 1) @(negedge clk);
        exp_bits++;
        tb_bit = (tb_bit + 1) % 8;
        if (tb_bit == 0) begin
            tb_ts = (tb_ts + 1) % 32;
            if (tb_ts == 0) tb_frame ^= 1;
        end
    endtask

    task automatic run(input int n, input int gap);
        for (int i = 0; i < n; i++) strobe(gap);
    endtask

    task automatic checkpoint(input string name);
        repeat (3) @(negedge clk);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_acks"}, mon_acks, exp_loads);
        check({name, "_underruns"}, mon_under, exp_under);
        check({name, "_bits"}, mon_bits, exp_bits);
    endtask

    task automatic clear_model();
        exp_q.delete();
        tb_bit    = 0;
        tb_ts     = 0;
        tb_frame  = 0;
        exp_loads = 0;
        exp_under = 0;
        exp_bits  = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        rst             = 1'b1;
        out_ready       = 1'b0;
        ctrl_do_framing = 1'b1;
        alarm           = 1'b0;
        drop_en         = 1'b0;
        ts0_val         = 8'hAA;
        clear_model();
        repeat (3) @(negedge clk);

        // reset state
        check("rst_out_bit", {31'd0, out_bit}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ack", {31'd0, in_ack}, 0);
        check("rst_underrun", {31'd0, status_underrun}, 0);
        check("rst_sof", {31'd0, status_sof}, 0);
        check("rst_in_ts", {27'd0, in_ts}, 0);
        rst = 1'b0;
        @(negedge clk);

        // framing on, sparse strobes, 3 frames: FAS, NFAS, FAS
        run(768, 15);
        checkpoint("framed");

        // alarm raised mid-frame (odd frame already loaded as 0xDF);
        // next even frame is FAS, following odd frame carries alarm 0xFF
        ts0_val = 8'h55;
        run(128, 2);
        alarm = 1'b1;
        run(128 + 256 + 256, 2);
        alarm = 1'b0;
        checkpoint("alarm");

        // transparent TS0 over an even and an odd frame
        ctrl_do_framing = 1'b0;
        run(512, 2);
        ctrl_do_framing = 1'b1;
        checkpoint("transparent");

        // source withholds TS5
        drop_en = 1'b1;
        run(256, 2);
        drop_en = 1'b0;
        checkpoint("underrun");

        // continuous out_ready, source answering 3 cycles after in_ack
        t0 = $time;
        run(256, 1);
        check("continuous_cycles", ($time - t0) / 10, 256);
        checkpoint("continuous");

        // reset during TS17 bit 3 (TS17 byte 0x11: that bit is 1)
        run(17 * 8 + 3, 2);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_out_valid", {31'd0, out_valid}, 1);
        rst       = 1'b1;
        out_ready = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_out_bit", {31'd0, out_bit}, 0);
        check("mid_rst_in_ack", {31'd0, in_ack}, 0);
        check("mid_rst_in_ts", {27'd0, in_ts}, 0);
        check("mid_rst_sof", {31'd0, status_sof}, 0);
        check("mid_rst_underrun", {31'd0, status_underrun}, 0);
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(16, 2);
        checkpoint("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
